// File: rtl/rx_pkg.sv
// Shared receive-path definitions: CRC-32 constants, Ethernet length limits and the
// frame-check FSM encoding.
package rx_pkg;

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    localparam int unsigned ETH_MIN_LEN = 64;
    localparam int unsigned ETH_MAX_LEN = 1522;

    typedef enum logic [1:0] {
        StIdle,
        StRecv,
        StDone
    } rx_state_e;

    typedef struct packed {
        logic crc;
        logic runt;
        logic too_long;
        logic phy;
    } rx_err_t;

endpackage

// File: rtl/crc32_d8.sv
// Combinational reflected CRC-32 update for one byte (LSB first).
module crc32_d8
    import rx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/rx_fcs_check.sv
// Strips the trailing FCS from a received frame, checks CRC-32, length and PHY errors,
// and reports a per-frame verdict plus saturating good/bad frame counters.
module rx_fcs_check
    import rx_pkg::*;
#(
    parameter int unsigned MIN_LEN = ETH_MIN_LEN,
    parameter int unsigned MAX_LEN = ETH_MAX_LEN,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             rx_clk,
    input  logic             resetn,
    input  logic [7:0]       in_data,
    input  logic             in_en,
    input  logic             in_err,
    output logic [7:0]       out_data,
    output logic             out_en,
    output logic             frame_done,
    output logic             frame_ok,
    output logic             err_crc,
    output logic             err_runt,
    output logic             err_long,
    output logic             err_phy,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    localparam int unsigned      LEN_W   = 11;
    localparam logic [LEN_W-1:0] LEN_SAT = '1;
    localparam logic [LEN_W-1:0] MIN_L   = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);

    rx_state_e        state_q, state_d;
    logic [3:0][7:0]  sr_q, sr_d;
    logic [2:0]       fill_q, fill_d;
    logic [31:0]      crc_q, crc_d, crc_next;
    logic [LEN_W-1:0] len_q, len_d;
    logic             phy_q, phy_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_en_q, out_en_d;
    rx_err_t          err_q, err_d;
    logic             ok_q, ok_d;
    logic [CNT_W-1:0] good_q, good_d, bad_q, bad_d;
    logic             frame_end;

    crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data    (in_data),
        .crc_out (crc_next)
    );

    assign frame_end = (state_q == StRecv) && !in_en;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_en) state_d = StRecv;
            StRecv:  if (!in_en) state_d = StDone;
            StDone:  state_d = in_en ? StRecv : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // A byte is consumed whenever in_en is high, so a frame may start in the DONE cycle.
    always_comb begin
        sr_d       = sr_q;
        fill_d     = fill_q;
        crc_d      = crc_q;
        len_d      = len_q;
        phy_d      = phy_q;
        out_data_d = out_data_q;
        out_en_d   = 1'b0;
        if (frame_end) begin
            fill_d = 3'd0;
            crc_d  = CRC_INIT;
            len_d  = '0;
            phy_d  = 1'b0;
        end else if (in_en) begin
            sr_d  = {sr_q[2:0], in_data};
            crc_d = crc_next;
            if (fill_q == 3'd4) begin
                out_en_d   = 1'b1;
                out_data_d = sr_q[3];
            end else begin
                fill_d = fill_q + 3'd1;
            end
            if (len_q != LEN_SAT) len_d = len_q + LEN_W'(1);
            if (in_err) phy_d = 1'b1;
        end
    end

    always_comb begin
        err_d  = '0;
        ok_d   = 1'b0;
        good_d = good_q;
        bad_d  = bad_q;
        if (frame_end) begin
            err_d.crc      = (crc_q != CRC_RESIDUE);
            err_d.runt     = (len_q < MIN_L);
            err_d.too_long = (len_q > MAX_L);
            err_d.phy      = phy_q;
            ok_d           = ~|err_d;
        end
        if (state_q == StDone) begin
            if (ok_q && (good_q != '1)) good_d = good_q + CNT_W'(1);
            if (!ok_q && (bad_q != '1)) bad_d = bad_q + CNT_W'(1);
        end
    end

    always_ff @(posedge rx_clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            sr_q       <= '0;
            fill_q     <= 3'd0;
            crc_q      <= CRC_INIT;
            len_q      <= '0;
            phy_q      <= 1'b0;
            out_data_q <= 8'h00;
            out_en_q   <= 1'b0;
            err_q      <= '0;
            ok_q       <= 1'b0;
            good_q     <= '0;
            bad_q      <= '0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            fill_q     <= fill_d;
            crc_q      <= crc_d;
            len_q      <= len_d;
            phy_q      <= phy_d;
            out_data_q <= out_data_d;
            out_en_q   <= out_en_d;
            err_q      <= err_d;
            ok_q       <= ok_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_en     = out_en_q;
    assign frame_done = (state_q == StDone);
    assign frame_ok   = ok_q;
    assign err_crc    = err_q.crc;
    assign err_runt   = err_q.runt;
    assign err_long   = err_q.too_long;
    assign err_phy    = err_q.phy;
    assign good_cnt   = good_q;
    assign bad_cnt    = bad_q;

endmodule

// File: tb/tb_rx_fcs_check.sv
// Self-checking bench for rx_fcs_check: table of frames plus hand-written gap, reset and
// counter-saturation sequences, with byte and verdict scoreboards.
module tb_rx_fcs_check;

    logic        rx_clk = 1'b0;
    logic        resetn = 1'b0;
    logic        sat_rstn = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_en = 1'b0;
    logic        in_err = 1'b0;

    logic [7:0]  out_data;
    logic        out_en, frame_done, frame_ok, err_crc, err_runt, err_long, err_phy;
    logic [15:0] good_cnt, bad_cnt;

    logic [7:0]  s_data;
    logic        s_en, s_done, s_ok, s_crc, s_runt, s_long, s_phy;
    logic [1:0]  s_good, s_bad;

    rx_fcs_check u_dut (
        .rx_clk     (rx_clk),
        .resetn     (resetn),
        .in_data    (in_data),
        .in_en      (in_en),
        .in_err     (in_err),
        .out_data   (out_data),
        .out_en     (out_en),
        .frame_done (frame_done),
        .frame_ok   (frame_ok),
        .err_crc    (err_crc),
        .err_runt   (err_runt),
        .err_long   (err_long),
        .err_phy    (err_phy),
        .good_cnt   (good_cnt),
        .bad_cnt    (bad_cnt)
    );

    // Narrow-counter copy fed the same stream, used to reach saturation quickly.
    rx_fcs_check #(.CNT_W(2)) u_sat (
        .rx_clk     (rx_clk),
        .resetn     (sat_rstn),
        .in_data    (in_data),
        .in_en      (in_en),
        .in_err     (in_err),
        .out_data   (s_data),
        .out_en     (s_en),
        .frame_done (s_done),
        .frame_ok   (s_ok),
        .err_crc    (s_crc),
        .err_runt   (s_runt),
        .err_long   (s_long),
        .err_phy    (s_phy),
        .good_cnt   (s_good),
        .bad_cnt    (s_bad)
    );

    always #5 rx_clk = ~rx_clk;

    typedef struct {
        int n;
        bit fcs;
        int flip;
        int perr;
        bit ok, crc, runt, lng, phy;
        int good, bad;
    } vec_t;

    typedef struct {
        bit ok, crc, runt, lng, phy, has_out;
    } verd_t;

    logic [7:0] sq[$];
    verd_t      vq[$];
    int errors = 0, checks = 0;
    int cyc = 0, n_out = 0, n_done = 0, t0 = 0, last_out = 0;
    bit lat_arm = 1'b0;
    bit prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'h0, d};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    always @(posedge rx_clk) cyc <= cyc + 1;

    always @(negedge rx_clk) begin
        logic [7:0] e;
        verd_t v;
        if (resetn) begin
            if (out_en) begin
                if (lat_arm) begin
                    check("first_out_latency", cyc - t0, 5);
                    lat_arm = 1'b0;
                end
                n_out++;
                last_out = cyc;
                if (sq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_byte: got %0h expected no output", out_data);
                end else begin
                    e = sq.pop_front();
                    check("out_data", out_data, e);
                end
            end
            if (prev_done && !frame_done)
                check("flags_clear", {frame_ok, err_crc, err_runt, err_long, err_phy}, 0);
            if (frame_done) begin
                n_done++;
                if (vq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_frame_done: got 1 expected 0");
                end else begin
                    v = vq.pop_front();
                    check("frame_ok", frame_ok, v.ok);
                    check("err_crc", err_crc, v.crc);
                    check("err_runt", err_runt, v.runt);
                    check("err_long", err_long, v.lng);
                    check("err_phy", err_phy, v.phy);
                    if (v.has_out) check("last_out_to_done", cyc - last_out, 1);
                end
            end
            prev_done = frame_done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic send(input int n, input bit fcs, input int flip, input int perr,
                        input verd_t v);
        logic [7:0]  b[$];
        logic [31:0] c;
        int pl;
        c  = 32'hFFFF_FFFF;
        pl = fcs ? n - 4 : n;
        for (int k = 0; k < pl; k++) begin
            b.push_back(8'(k));
            c = crc_step(c, 8'(k));
        end
        if (fcs) begin
            c = ~c;
            for (int j = 0; j < 4; j++) b.push_back(c[8*j +: 8]);
        end
        if (flip >= 0) b[flip] = b[flip] ^ 8'h01;
        vq.push_back(v);
        for (int k = 0; k < n; k++) begin
            @(posedge rx_clk);
            #1;
            in_en   = 1'b1;
            in_data = b[k];
            in_err  = (k == perr);
            if (k < n - 4) sq.push_back(b[k]);
            if (k == 0 && n > 4) begin
                t0      = cyc;
                lat_arm = 1'b1;
            end
        end
        @(posedge rx_clk);
        #1;
        in_en   = 1'b0;
        in_err  = 1'b0;
        in_data = 8'h00;
    endtask

    function automatic verd_t good_verd();
        verd_t v;
        v = '{ok: 1, crc: 0, runt: 0, lng: 0, phy: 0, has_out: 1};
        return v;
    endfunction

    vec_t tbl[6];

    initial begin
        int b0, d0;
        verd_t v;

        tbl[0] = '{n: 64,   fcs: 1, flip: -1, perr: -1, ok: 1, crc: 0, runt: 0, lng: 0, phy: 0,
                   good: 1, bad: 0};
        tbl[1] = '{n: 64,   fcs: 1, flip: 10, perr: -1, ok: 0, crc: 1, runt: 0, lng: 0, phy: 0,
                   good: 1, bad: 1};
        tbl[2] = '{n: 20,   fcs: 1, flip: -1, perr: -1, ok: 0, crc: 0, runt: 1, lng: 0, phy: 0,
                   good: 1, bad: 2};
        tbl[3] = '{n: 3,    fcs: 0, flip: -1, perr: -1, ok: 0, crc: 1, runt: 1, lng: 0, phy: 0,
                   good: 1, bad: 3};
        tbl[4] = '{n: 1530, fcs: 1, flip: -1, perr: -1, ok: 0, crc: 0, runt: 0, lng: 1, phy: 0,
                   good: 1, bad: 4};
        tbl[5] = '{n: 64,   fcs: 1, flip: -1, perr: 7,  ok: 0, crc: 0, runt: 0, lng: 0, phy: 1,
                   good: 1, bad: 5};

        @(negedge rx_clk);
        check("reset_outputs", {out_data, out_en, frame_done, frame_ok,
                                err_crc, err_runt, err_long, err_phy}, 0);
        check("reset_good_cnt", good_cnt, 0);
        check("reset_bad_cnt", bad_cnt, 0);
        @(posedge rx_clk);
        #1;
        resetn   = 1'b1;
        sat_rstn = 1'b1;
        repeat (2) @(posedge rx_clk);

        for (int i = 0; i < 6; i++) begin
            v = '{ok: tbl[i].ok, crc: tbl[i].crc, runt: tbl[i].runt, lng: tbl[i].lng,
                  phy: tbl[i].phy, has_out: (tbl[i].n > 4)};
            b0 = n_out;
            send(tbl[i].n, tbl[i].fcs, tbl[i].flip, tbl[i].perr, v);
            repeat (8) @(posedge rx_clk);
            #1;
            check("frame_done_seen", vq.size(), 0);
            check("bytes_out", n_out - b0, (tbl[i].n > 4) ? tbl[i].n - 4 : 0);
            check("good_cnt", good_cnt, tbl[i].good);
            check("bad_cnt", bad_cnt, tbl[i].bad);
        end

        // Two good frames with the minimum one-cycle gap.
        b0 = n_out;
        d0 = n_done;
        send(64, 1, -1, -1, good_verd());
        send(64, 1, -1, -1, good_verd());
        repeat (8) @(posedge rx_clk);
        #1;
        check("pair_bytes", n_out - b0, 120);
        check("pair_done", n_done - d0, 2);
        check("pair_good_cnt", good_cnt, 3);
        check("pair_leftover", sq.size(), 0);
        check("sat_good_reached", s_good, 2'b11);

        // Asynchronous reset in the middle of a frame.
        d0 = n_done;
        for (int k = 0; k < 30; k++) begin
            @(posedge rx_clk);
            #1;
            in_en   = 1'b1;
            in_data = 8'(k);
            if (k < 26) sq.push_back(8'(k));
        end
        @(posedge rx_clk);
        #1;
        check("out_en_before_reset", out_en, 1);
        in_en  = 1'b0;
        resetn = 1'b0;
        #1;
        check("out_en_in_reset", out_en, 0);
        check("done_in_reset", frame_done, 0);
        sq.delete();
        lat_arm = 1'b0;
        @(posedge rx_clk);
        #1;
        resetn = 1'b1;
        repeat (8) @(posedge rx_clk);
        #1;
        check("no_done_after_reset", n_done - d0, 0);
        check("good_cnt_cleared", good_cnt, 0);
        check("bad_cnt_cleared", bad_cnt, 0);

        send(64, 1, -1, -1, good_verd());
        repeat (8) @(posedge rx_clk);
        #1;
        check("post_reset_good_cnt", good_cnt, 1);
        check("post_reset_bad_cnt", bad_cnt, 0);

        send(64, 1, -1, -1, good_verd());
        repeat (8) @(posedge rx_clk);
        #1;
        check("sat_good_hold", s_good, 2'b11);
        check("sat_bad_hold", s_bad, 2'b11);
        check("final_good_cnt", good_cnt, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rx_fcs_check.md
Name: rx_fcs_check

Overview:
- Receive-path stage directly downstream of the preamble/SFD stripper and directly upstream of the majority-vote stage.
- Takes the post-SFD byte stream of one Ethernet frame (destination MAC through FCS) and strips the trailing 4-byte FCS.
- Checks CRC-32 and length, then emits the payload bytes with a frame-end verdict so later stages can discard corrupted copies.
- Runs entirely in the buffered RGMII receive clock domain.

Parameters:
- MIN_LEN, 64, minimum legal frame length in bytes including FCS.
- MAX_LEN, 1522, maximum legal frame length in bytes including FCS.
- CNT_W, 16, width of the good/bad frame counters.

Ports:
- rx_clk  in  1  buffered RGMII receive clock; the only clock.
- resetn  in  1  asynchronous active-low reset.
- in_data  in  8  post-SFD frame byte.
- in_en  in  1  high for every byte of a frame, contiguous; a low cycle ends the frame.
- in_err  in  1  PHY data error, sampled with in_en.
- out_data  out  8  payload byte, FCS removed.
- out_en  out  1  out_data valid.
- frame_done  out  1  one-cycle pulse when a frame ends.
- frame_ok  out  1  verdict, valid only while frame_done=1.
- err_crc, err_runt, err_long, err_phy  out  1 each  reason flags, valid with frame_done.
- good_cnt  out  CNT_W  frames ending with frame_ok=1, saturating.
- bad_cnt  out  CNT_W  frames ending with frame_ok=0, saturating.

Behaviour:
- Reset: all outputs 0, counters 0, CRC register 0xFFFFFFFF, state IDLE, delay line cleared.
- FSM IDLE -> RECV on in_en=1.
- RECV -> DONE on the first in_en=0.
- DONE (exactly one cycle) -> IDLE; if in_en=1 in DONE, that byte starts a new frame (state goes to RECV and the byte is consumed).
- Delay line: 4-byte shift register plus fill counter (0..4).
  - In RECV, each in_en byte shifts in.
  - When fill==4, the byte shifted out drives out_data with out_en=1, registered.
  - Net latency from in_data to out_data is 5 cycles.
  - The final 4 bytes (the FCS) are never emitted.
  - A frame of 4 bytes or fewer emits nothing.
- CRC: reflected CRC-32 (poly 0xEDB88320, LSB first, init 0xFFFFFFFF), 8 bits per cycle, computed over all bytes including the FCS.
  - Good iff the final register equals 0xDEBB20E3.
- Length counter: 11 bits, saturating at 2047; counts every in_en byte including the FCS.
- Verdict, evaluated on the RECV->DONE transition:
  - err_crc = residue mismatch.
  - err_runt = length < MIN_LEN.
  - err_long = length > MAX_LEN.
  - err_phy = in_err seen during the frame (sticky).
  - frame_ok = none of the four flags set.
- frame_done asserts in DONE; last out_en precedes frame_done by exactly 1 cycle.
- Flags and frame_ok return to 0 the cycle after frame_done.
- Counters increment in DONE and hold at all-ones.
- End of frame clears the fill counter, resets CRC to 0xFFFFFFFF and clears err_phy; bytes left in the delay line are discarded.
- Minimum inter-frame gap is 1 cycle and must be supported.
- Asynchronous reset mid-frame: output stops immediately, no frame_done, counters cleared.

Decomposition:
- Shared package rx_pkg:
  - CRC_INIT = 0xFFFFFFFF.
  - CRC_POLY = 0xEDB88320.
  - CRC_RESIDUE = 0xDEBB20E3.
  - ETH_MIN_LEN / ETH_MAX_LEN defaults.
  - FSM state encoding (IDLE/RECV/DONE).
- Sub-module crc32_d8: combinational next-CRC for one byte (crc_in[31:0], data[7:0] -> crc_out). Reused later by the TX FCS inserter.

Test Plan:
- 64-byte frame: bytes 0x00..0x3B followed by the correct FCS from the bench model -> 60 bytes 0x00..0x3B on out_data, first out_en 5 cycles after the first in_en; frame_done with frame_ok=1; good_cnt=1.
- Same frame with byte 10 XOR 0x01 -> 60 bytes still emitted; frame_done with err_crc=1 and frame_ok=0; bad_cnt=1.
- 20-byte frame with a correct FCS -> 16 bytes out; err_runt=1, err_crc=0. A 3-byte frame -> no out_en, err_runt=1.
- 1530-byte frame with a correct FCS -> 1526 bytes out, err_long=1. The same 64-byte frame with in_err pulsed once -> err_phy=1.
- Two good 64-byte frames separated by a 1-cycle gap -> two frame_done pulses, 120 bytes total, good_cnt=2, and no byte leaks between frames.
- resetn low for 1 cycle at byte 30 of a frame -> out_en drops with no frame_done; the following good frame yields good_cnt=1. Counter saturation: force good_cnt to 0xFFFE, send 3 good frames -> good_cnt holds at 0xFFFF.
